// File: rtl/oven_timer_ctrl_if.sv
// Front-panel bundle between the keypad/door sensors, the cook-timer
// sequencer and the display/heater/buzzer consumers.
interface oven_timer_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        start;
  logic        stop;
  logic        door_open;
  logic [12:0] current_time;
  logic        display_blank;
  logic        heater_on;
  logic        done_beep;
  logic [2:0]  state_o;

  // Panel side: drives keys/buttons/door and observes the timer outputs.
  modport master (
    output key_valid, key_digit, start, stop, door_open,
    input  current_time, display_blank, heater_on, done_beep, state_o
  );

  // Timer side: consumes panel inputs and owns every output.
  modport slave (
    input  key_valid, key_digit, start, stop, door_open,
    output current_time, display_blank, heater_on, done_beep, state_o
  );
endinterface

// File: rtl/oven_timer_ctrl.sv
// Cook-timer sequencer: keypad time entry, 1 Hz countdown with pause/resume,
// heater enable and end-of-cook beep. All outputs come straight from flops.
module oven_timer_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int MAX_SECONDS = 3599,
  parameter int BEEP_TICKS  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  oven_timer_ctrl_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  // Only the three newest digits are stored: the oldest one is already
  // folded into current_time and drops off on the next key press.
  logic [3:0]      d2_q, d1_q, d0_q;
  logic [PW-1:0]   presc_q;
  logic [BW-1:0]   beep_cnt_q;
  logic [12:0]     time_q;
  logic            blank_q;
  logic            heater_q;
  logic            beep_q;

  logic            digit_ok_d;
  logic            tick_d;
  logic            last_beep_d;
  logic            to_idle_d;
  logic [PW-1:0]   presc_d;
  logic [12:0]     entry_shift_d;

  // MM:SS digits to seconds; the seconds pair may exceed 59 (0:99 = 99 s).
  function automatic logic [12:0] entry_time(input logic [3:0] a3, input logic [3:0] a2,
                                             input logic [3:0] a1, input logic [3:0] a0);
    logic [12:0] mins;
    logic [12:0] secs;
    logic [12:0] tot;
    mins = 13'(a3) * 13'd10 + 13'(a2);
    secs = 13'(a1) * 13'd10 + 13'(a0);
    tot  = mins * 13'd60 + secs;
    return (tot > 13'(MAX_SECONDS)) ? 13'(MAX_SECONDS) : tot;
  endfunction

  assign digit_ok_d    = bus.key_valid && (bus.key_digit <= 4'd9);
  assign tick_d        = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d       = tick_d ? '0 : presc_q + PW'(1);
  assign last_beep_d   = (beep_cnt_q == BW'(BEEP_TICKS - 1));
  assign entry_shift_d = entry_time(d2_q, d1_q, d0_q, bus.key_digit);

  // Every path back to IDLE clears the same state, so decide it in one place.
  always_comb begin
    to_idle_d = 1'b0;
    case (state_q)
      S_IDLE:           to_idle_d = 1'b0;
      S_ENTRY, S_PAUSE: to_idle_d = bus.stop;
      S_RUN:            to_idle_d = 1'b0;
      S_DONE:           to_idle_d = bus.stop || digit_ok_d || (tick_d && last_beep_d);
      default:          to_idle_d = 1'b1;
    endcase
  end

  // Sequencer with registered outputs; reset drops the heater immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      d2_q       <= '0;
      d1_q       <= '0;
      d0_q       <= '0;
      presc_q    <= '0;
      beep_cnt_q <= '0;
      time_q     <= '0;
      blank_q    <= 1'b1;
      heater_q   <= 1'b0;
      beep_q     <= 1'b0;
    end else if (to_idle_d) begin
      state_q    <= S_IDLE;
      d2_q       <= '0;
      d1_q       <= '0;
      d0_q       <= '0;
      presc_q    <= '0;
      beep_cnt_q <= '0;
      time_q     <= '0;
      blank_q    <= 1'b1;
      heater_q   <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (digit_ok_d) begin
            state_q <= S_ENTRY;
            d2_q    <= '0;
            d1_q    <= '0;
            d0_q    <= bus.key_digit;
            time_q  <= 13'(bus.key_digit);
            blank_q <= 1'b0;
          end
        end
        S_ENTRY: begin
          // A start press shadows a same-cycle key even when it is refused.
          if (bus.start) begin
            if (time_q != 13'd0 && !bus.door_open) begin
              state_q  <= S_RUN;
              heater_q <= 1'b1;
              presc_q  <= '0;
            end
          end else if (digit_ok_d) begin
            d2_q   <= d1_q;
            d1_q   <= d0_q;
            d0_q   <= bus.key_digit;
            time_q <= entry_shift_d;
          end
        end
        S_RUN: begin
          // Pausing freezes the prescaler so resume finishes the partial second.
          if (bus.stop || bus.door_open) begin
            state_q  <= S_PAUSE;
            heater_q <= 1'b0;
          end else begin
            presc_q <= presc_d;
            if (tick_d) begin
              if (time_q <= 13'd1) begin
                state_q    <= S_DONE;
                heater_q   <= 1'b0;
                beep_q     <= 1'b1;
                beep_cnt_q <= '0;
                time_q     <= '0;
              end else begin
                time_q <= time_q - 13'd1;
              end
            end
          end
        end
        S_PAUSE: begin
          if (bus.start && !bus.door_open) begin
            state_q  <= S_RUN;
            heater_q <= 1'b1;
          end
        end
        S_DONE: begin
          presc_q <= presc_d;
          if (tick_d) beep_cnt_q <= beep_cnt_q + BW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.current_time  = time_q;
  assign bus.display_blank = blank_q;
  assign bus.heater_on     = heater_q;
  assign bus.done_beep     = beep_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_oven_timer_ctrl.sv
// Bench for the cook-timer sequencer: vector table, corner-case sequences
// and a randomized run against a seconds/digits-level reference model.
module tb_oven_timer_ctrl;
  localparam int TICK_DIV    = 4;
  localparam int MAX_SECONDS = 3599;
  localparam int BEEP_TICKS  = 3;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic clk = 1'b0;
  logic reset_n;
  oven_timer_ctrl_if bus();

  oven_timer_ctrl #(
    .TICK_DIV(TICK_DIV), .MAX_SECONDS(MAX_SECONDS), .BEEP_TICKS(BEEP_TICKS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        kv;
    logic [3:0]  kd;
    logic        st;
    logic        sp;
    logic        dr;
    logic [2:0]  es;
    logic [12:0] et;
    logic        eb;
    logic        eh;
  } vec_t;

  vec_t vecs[22];

  // Reference model: mode, list of entered digits, seconds, cycles into second.
  int m_mode;
  int m_keys[$];
  int m_secs;
  int m_frac;
  int m_beeps;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic kv, input logic [3:0] kd, input logic st,
                       input logic sp, input logic dr);
    bus.key_valid = kv;
    bus.key_digit = kd;
    bus.start     = st;
    bus.stop      = sp;
    bus.door_open = dr;
    @(posedge clk);
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
  endtask

  function automatic int model_entry();
    int d[4];
    int n;
    int t;
    n = m_keys.size();
    for (int i = 0; i < 4; i++) d[i] = (i >= 4 - n) ? m_keys[i - (4 - n)] : 0;
    t = (10 * d[0] + d[1]) * 60 + 10 * d[2] + d[3];
    return (t > MAX_SECONDS) ? MAX_SECONDS : t;
  endfunction

  task automatic model_clear();
    m_mode = M_IDLE;
    m_keys.delete();
    m_secs  = 0;
    m_frac  = 0;
    m_beeps = 0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] kd, input logic st,
                            input logic sp, input logic dr);
    logic vk;
    vk = kv && (kd <= 4'd9);
    case (m_mode)
      M_IDLE: if (vk) begin
        m_keys.delete();
        m_keys.push_back(int'(kd));
        m_secs = model_entry();
        m_mode = M_ENTRY;
      end
      M_ENTRY: begin
        if (sp) model_clear();
        else if (st) begin
          if (m_secs != 0 && !dr) begin m_mode = M_RUN; m_frac = 0; end
        end else if (vk) begin
          m_keys.push_back(int'(kd));
          if (m_keys.size() > 4) void'(m_keys.pop_front());
          m_secs = model_entry();
        end
      end
      M_RUN: begin
        if (sp || dr) m_mode = M_PAUSE;
        else begin
          m_frac++;
          if (m_frac == TICK_DIV) begin
            m_frac = 0;
            m_secs--;
            if (m_secs == 0) begin m_mode = M_DONE; m_beeps = 0; end
          end
        end
      end
      M_PAUSE: begin
        if (sp) model_clear();
        else if (st && !dr) m_mode = M_RUN;
      end
      M_DONE: begin
        if (sp || vk) model_clear();
        else begin
          m_frac++;
          if (m_frac == TICK_DIV) begin
            m_frac = 0;
            m_beeps++;
            if (m_beeps == BEEP_TICKS) model_clear();
          end
        end
      end
      default: model_clear();
    endcase
  endtask

  initial begin
    logic door_r;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.door_open = 1'b0;
    reset_n       = 1'b0;

    // Vector table: {key_valid, digit, start, stop, door} -> {state, time, blank, heater}
    vecs[0]  = '{1, 1,  0, 0, 0, 1, 1,    0, 0};
    vecs[1]  = '{1, 3,  0, 0, 0, 1, 13,   0, 0};
    vecs[2]  = '{1, 0,  0, 0, 0, 1, 90,   0, 0};
    vecs[3]  = '{1, 7,  0, 0, 0, 1, 787,  0, 0};
    vecs[4]  = '{1, 12, 0, 0, 0, 1, 787,  0, 0};
    vecs[5]  = '{0, 0,  0, 1, 0, 0, 0,    1, 0};
    vecs[6]  = '{1, 9,  0, 0, 0, 1, 9,    0, 0};
    vecs[7]  = '{1, 9,  0, 0, 0, 1, 99,   0, 0};
    vecs[8]  = '{1, 9,  0, 0, 0, 1, 639,  0, 0};
    vecs[9]  = '{1, 9,  0, 0, 0, 1, 3599, 0, 0};
    vecs[10] = '{1, 12, 0, 0, 0, 1, 3599, 0, 0};
    vecs[11] = '{1, 5,  0, 0, 0, 1, 3599, 0, 0};
    vecs[12] = '{0, 0,  0, 1, 0, 0, 0,    1, 0};
    vecs[13] = '{1, 0,  0, 0, 0, 1, 0,    0, 0};
    vecs[14] = '{0, 0,  1, 0, 0, 1, 0,    0, 0};
    vecs[15] = '{1, 0,  0, 0, 0, 1, 0,    0, 0};
    vecs[16] = '{0, 0,  0, 1, 0, 0, 0,    1, 0};
    vecs[17] = '{0, 0,  1, 0, 0, 0, 0,    1, 0};
    vecs[18] = '{1, 10, 0, 0, 0, 0, 0,    1, 0};
    vecs[19] = '{1, 4,  0, 0, 0, 1, 4,    0, 0};
    vecs[20] = '{0, 0,  1, 0, 1, 1, 4,    0, 0};
    vecs[21] = '{0, 0,  0, 1, 0, 0, 0,    1, 0};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_state", bus.state_o, 0);
    chk("rst_time", bus.current_time, 0);
    chk("rst_blank", bus.display_blank, 1);
    chk("rst_heater", bus.heater_on, 0);
    chk("rst_beep", bus.done_beep, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].kv, vecs[i].kd, vecs[i].st, vecs[i].sp, vecs[i].dr);
      chk($sformatf("vec%0d_state", i), bus.state_o, vecs[i].es);
      chk($sformatf("vec%0d_time", i), bus.current_time, vecs[i].et);
      chk($sformatf("vec%0d_blank", i), bus.display_blank, vecs[i].eb);
      chk($sformatf("vec%0d_heater", i), bus.heater_on, vecs[i].eh);
      $display("vec %0d: state=%0d time=%0d blank=%0b heater=%0b", i,
               bus.state_o, bus.current_time, bus.display_blank, bus.heater_on);
    end

    // Countdown 3 s to DONE, then 12-cycle beep
    drive(1, 3, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("runA_state", bus.state_o, M_RUN);
    chk("runA_heater", bus.heater_on, 1);
    chk("runA_time0", bus.current_time, 3);
    for (int i = 1; i <= 12; i++) begin
      drive(0, 0, 0, 0, 0);
      chk($sformatf("runA_time_c%0d", i), bus.current_time, 3 - i / 4);
      chk($sformatf("runA_state_c%0d", i), bus.state_o, (i < 12) ? M_RUN : M_DONE);
    end
    chk("doneA_heater", bus.heater_on, 0);
    chk("doneA_beep", bus.done_beep, 1);
    for (int j = 1; j <= 11; j++) begin
      drive(0, 0, 0, 0, 0);
      chk($sformatf("doneA_beep_c%0d", j), bus.done_beep, 1);
    end
    drive(0, 0, 0, 0, 0);
    chk("doneA_end_state", bus.state_o, M_IDLE);
    chk("doneA_end_beep", bus.done_beep, 0);
    $display("seq countdown: state=%0d beep=%0b", bus.state_o, bus.done_beep);

    // Door pause two cycles into a second, resume keeps the partial second
    drive(1, 5, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("pause_state", bus.state_o, M_PAUSE);
    chk("pause_heater", bus.heater_on, 0);
    drive(0, 0, 1, 0, 1);
    chk("pause_start_door", bus.state_o, M_PAUSE);
    drive(0, 0, 0, 0, 0);
    chk("pause_time", bus.current_time, 5);
    drive(0, 0, 1, 0, 0);
    chk("resume_state", bus.state_o, M_RUN);
    chk("resume_heater", bus.heater_on, 1);
    drive(0, 0, 0, 0, 0);
    chk("resume_time_c1", bus.current_time, 5);
    drive(0, 0, 0, 0, 0);
    chk("resume_time_c2", bus.current_time, 4);
    drive(0, 0, 0, 1, 0);
    chk("stop_to_pause", bus.state_o, M_PAUSE);
    drive(0, 0, 1, 1, 0);
    chk("pause_startstop_state", bus.state_o, M_IDLE);
    chk("pause_startstop_time", bus.current_time, 0);
    chk("pause_startstop_blank", bus.display_blank, 1);
    $display("seq pause: state=%0d time=%0d", bus.state_o, bus.current_time);

    // Key during DONE returns to IDLE without capturing the digit
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    chk("doneC_state", bus.state_o, M_DONE);
    drive(1, 5, 0, 0, 0);
    chk("doneC_key_state", bus.state_o, M_IDLE);
    chk("doneC_key_time", bus.current_time, 0);
    drive(0, 0, 0, 0, 0);
    chk("doneC_after_state", bus.state_o, M_IDLE);
    $display("seq done-key: state=%0d time=%0d", bus.state_o, bus.current_time);

    // Asynchronous reset mid-RUN
    drive(1, 2, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("rstD_pre_heater", bus.heater_on, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstD_state", bus.state_o, 0);
    chk("rstD_heater", bus.heater_on, 0);
    chk("rstD_blank", bus.display_blank, 1);
    chk("rstD_time", bus.current_time, 0);
    chk("rstD_beep", bus.done_beep, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("rstD_release", bus.state_o, M_IDLE);
    $display("seq async reset: state=%0d heater=%0b", bus.state_o, bus.heater_on);

    // Randomized run against the reference model
    model_clear();
    door_r = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      int r;
      logic kv, st, sp;
      logic [3:0] kd;
      logic [18:0] exp_v, act_v;
      r  = int'($urandom_range(0, 999));
      kd = 4'($urandom_range(0, 11));
      kv = 1'b0; st = 1'b0; sp = 1'b0;
      if (m_mode == M_RUN || m_mode == M_DONE) begin
        if (r < 20) kv = 1'b1; else if (r < 30) sp = 1'b1;
        if ($urandom_range(0, 63) == 0) door_r = ~door_r;
      end else begin
        if (r < 350) kv = 1'b1; else if (r < 650) st = 1'b1; else if (r < 690) sp = 1'b1;
        if ($urandom_range(0, 7) == 0) door_r = ~door_r;
      end
      model_step(kv, kd, st, sp, door_r);
      drive(kv, kd, st, sp, door_r);
      exp_v = {3'(m_mode), 13'(m_secs), (m_mode == M_IDLE), (m_mode == M_RUN), (m_mode == M_DONE)};
      act_v = {bus.state_o, bus.current_time, bus.display_blank, bus.heater_on, bus.done_beep};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL rand_c%0d: got state=%0d time=%0d blank=%0b heater=%0b beep=%0b expected state=%0d time=%0d blank=%0b heater=%0b beep=%0b",
                 c, act_v[18:16], act_v[15:3], act_v[2], act_v[1], act_v[0],
                 exp_v[18:16], exp_v[15:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
